// File: rtl/sel_scan4.sv
// Registered select sequencer for a downstream 4:1 mux.
// It steps through the enabled channels at a programmable rate and strobes on every change.
module sel_scan4 #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             hold,
    input  logic [DIV_W-1:0] div,
    input  logic [3:0]       mask,
    output logic [1:0]       s,
    output logic             stb,
    output logic             wrap,
    output logic             active
);

    logic [DIV_W-1:0] r_cnt;
    logic [1:0]       r_s;
    logic             r_stb;
    logic             r_wrap;
    logic             r_active;

    logic             w_tick;
    logic [1:0]       w_nxt;
    logic             w_found;
    logic             w_adv;

    // >= rather than == so that lowering div below the running count cannot lock up.
    assign w_tick = en && (r_cnt >= div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Search s+1 .. s+4; the current channel is considered last.
    always_comb begin
        w_nxt   = r_s;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && mask[r_s + 2'(k)]) begin
                w_nxt   = r_s + 2'(k);
                w_found = 1'b1;
            end
        end
    end

    assign w_adv = w_tick && !hold && w_found && (w_nxt != r_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s      <= 2'd0;
            r_stb    <= 1'b0;
            r_wrap   <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_active <= |mask;
            if (w_adv) begin
                r_s    <= w_nxt;
                r_stb  <= 1'b1;
                r_wrap <= (w_nxt < r_s);
            end else begin
                r_stb  <= 1'b0;
                r_wrap <= 1'b0;
            end
        end
    end

    assign s      = r_s;
    assign stb    = r_stb;
    assign wrap   = r_wrap;
    assign active = r_active;

endmodule

// File: tb/tb_sel_scan4.sv
// Directed, table-driven bench for sel_scan4 with hand-computed expectations.
module tb_sel_scan4;

    localparam int unsigned DIV_W = 16;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             hold;
    logic [DIV_W-1:0] div;
    logic [3:0]       mask;
    logic [1:0]       s;
    logic             stb;
    logic             wrap;
    logic             active;

    sel_scan4 #(.DIV_W(DIV_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .hold   (hold),
        .div    (div),
        .mask   (mask),
        .s      (s),
        .stb    (stb),
        .wrap   (wrap),
        .active (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        logic             en;
        logic             hold;
        logic [DIV_W-1:0] div;
        logic [3:0]       mask;
        logic [1:0]       s;
        logic             stb;
        logic             wrap;
        logic             active;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_bad;

    function automatic void add(input string tag, input logic e, input logic h,
                                input logic [DIV_W-1:0] d, input logic [3:0] m,
                                input logic [1:0] xs, input logic xstb, input logic xwrap,
                                input logic xact);
        vec_t v;
        v.tag = tag; v.en = e; v.hold = h; v.div = d; v.mask = m;
        v.s = xs; v.stb = xstb; v.wrap = xwrap; v.active = xact;
        vecs.push_back(v);
    endfunction

    task automatic check(input string tag, input logic [1:0] xs, input logic xstb,
                         input logic xwrap, input logic xact);
        n_vec++;
        if (s !== xs || stb !== xstb || wrap !== xwrap || active !== xact) begin
            n_bad++;
            $display("FAIL %s: got s=%0d stb=%0b wrap=%0b active=%0b, expected s=%0d stb=%0b wrap=%0b active=%0b",
                     tag, s, stb, wrap, active, xs, xstb, xwrap, xact);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        // free run, div=0
        add("free", 1, 0, 0, 4'hF, 1, 1, 0, 1);
        add("free", 1, 0, 0, 4'hF, 2, 1, 0, 1);
        add("free", 1, 0, 0, 4'hF, 3, 1, 0, 1);
        add("free", 1, 0, 0, 4'hF, 0, 1, 1, 1);
        add("free", 1, 0, 0, 4'hF, 1, 1, 0, 1);
        // prescale div=3
        for (int i = 0; i < 3; i++) add("pre", 1, 0, 3, 4'hF, 1, 0, 0, 1);
        add("pre", 1, 0, 3, 4'hF, 2, 1, 0, 1);
        for (int i = 0; i < 3; i++) add("pre", 1, 0, 3, 4'hF, 2, 0, 0, 1);
        add("pre", 1, 0, 3, 4'hF, 3, 1, 0, 1);
        add("pre_en", 1, 0, 3, 4'hF, 3, 0, 0, 1);
        for (int i = 0; i < 5; i++) add("pre_en", 0, 0, 3, 4'hF, 3, 0, 0, 1);
        for (int i = 0; i < 2; i++) add("pre_en", 1, 0, 3, 4'hF, 3, 0, 0, 1);
        add("pre_en", 1, 0, 3, 4'hF, 0, 1, 1, 1);
        // skip mask
        add("skip", 1, 0, 0, 4'b1010, 1, 1, 0, 1);
        add("skip", 1, 0, 0, 4'b1010, 3, 1, 0, 1);
        add("skip", 1, 0, 0, 4'b1010, 1, 1, 1, 1);
        add("skip", 1, 0, 0, 4'b1010, 3, 1, 0, 1);
        add("skip_one", 1, 0, 0, 4'b0100, 2, 1, 1, 1);
        for (int i = 0; i < 3; i++) add("skip_one", 1, 0, 0, 4'b0100, 2, 0, 0, 1);
        // empty mask
        for (int i = 0; i < 10; i++) add("empty", 1, 0, 0, 4'h0, 2, 0, 0, 0);
        add("restore", 1, 0, 0, 4'h1, 0, 1, 1, 1);
        // hold across a tick: tick lost, not replayed
        for (int i = 0; i < 8; i++) add("hold", 1, 1, 7, 4'hF, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) add("hold_rel", 1, 0, 7, 4'hF, 0, 0, 0, 1);
        add("hold_rel", 1, 0, 7, 4'hF, 1, 1, 0, 1);
        // lower div below running count
        for (int i = 0; i < 5; i++) add("div", 1, 0, 7, 4'hF, 1, 0, 0, 1);
        add("div_low", 1, 0, 2, 4'hF, 2, 1, 0, 1);
        for (int i = 0; i < 2; i++) add("div_low", 1, 0, 2, 4'hF, 2, 0, 0, 1);
        add("div_low", 1, 0, 2, 4'hF, 3, 1, 0, 1);

        rst_n = 1'b0;
        en    = 1'b0;
        hold  = 1'b0;
        div   = '0;
        mask  = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            en   = vecs[i].en;
            hold = vecs[i].hold;
            div  = vecs[i].div;
            mask = vecs[i].mask;
            @(posedge clk);
            #1;
            check(vecs[i].tag, vecs[i].s, vecs[i].stb, vecs[i].wrap, vecs[i].active);
        end

        // Async reset between edges while s=3, stb=1
        check("pre_areset", 3, 1, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("areset_hold", 0, 0, 0, 0);
        rst_n = 1'b1;
        en    = 1'b1;
        div   = 2;
        mask  = 4'hF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("post_reset", 0, 0, 0, 1);
        end
        @(posedge clk);
        #1;
        check("post_reset_adv", 1, 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
